// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the port arbiter and the ram1 wrapper.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface ram_port_arbiter_if;
    // Port A: instruction fetch, read-only
    logic        a_req;
    logic [7:0]  a_addr;
    logic        a_gnt;
    logic        a_rvalid;
    logic [15:0] a_rdata;
    // Port B: data load/store
    logic        b_req;
    logic        b_we;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [15:0] b_rdata;
    // ram1 side
    logic        ram_w_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_d_in;
    logic [15:0] ram_d_out;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_d_out,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        output ram_w_en, ram_addr, ram_d_in
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_d_out,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        input  ram_w_en, ram_addr, ram_d_in
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port 256x16 ram1 between fetch (A, read-only) and LSU (B, read/write).
// One access per cycle; a {valid, owner} tag pipeline steers read data back after RD_LAT.
module ram_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input logic              clk,
    input logic              rst,
    ram_port_arbiter_if.slave bus
);
    localparam int DEPTH = 1 + RD_LAT;

    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

    owner_e             last;
    logic               gnt_a, gnt_b;
    logic               w_en_q;
    logic [7:0]         addr_q;
    logic [15:0]        d_in_q;
    logic [DEPTH-1:0]   vld_pipe;
    logic [DEPTH-1:0]   own_pipe;
    logic               a_rvalid_q, b_rvalid_q;
    logic [15:0]        a_rdata_q, b_rdata_q;

    // Grants are suppressed while reset is asserted so nothing is accepted and dropped.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (bus.a_req && bus.b_req) begin
                if (FIXED_PRIO != 0 || last == OWN_A) gnt_b = 1'b1;
                else                                  gnt_a = 1'b1;
            end else begin
                gnt_a = bus.a_req;
                gnt_b = bus.b_req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q <= 1'b0;
            addr_q <= '0;
            d_in_q <= '0;
            last   <= OWN_B;
        end else begin
            w_en_q <= gnt_b & bus.b_we;
            if (gnt_a) begin
                addr_q <= bus.a_addr;
                d_in_q <= '0;
                last   <= OWN_A;
            end else if (gnt_b) begin
                addr_q <= bus.b_addr;
                d_in_q <= bus.b_wdata;
                last   <= OWN_B;
            end
        end
    end

    // Tag enters alongside the issue register and exits the cycle ram_d_out is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-2:0], gnt_a | (gnt_b & ~bus.b_we)};
            own_pipe <= {own_pipe[DEPTH-2:0], gnt_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= vld_pipe[DEPTH-1] & ~own_pipe[DEPTH-1];
            b_rvalid_q <= vld_pipe[DEPTH-1] &  own_pipe[DEPTH-1];
            if (vld_pipe[DEPTH-1] && !own_pipe[DEPTH-1]) a_rdata_q <= bus.ram_d_out;
            if (vld_pipe[DEPTH-1] &&  own_pipe[DEPTH-1]) b_rdata_q <= bus.ram_d_out;
        end
    end

    assign bus.a_gnt    = gnt_a;
    assign bus.b_gnt    = gnt_b;
    assign bus.ram_w_en = w_en_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_d_in = d_in_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: u0 round-robin RD_LAT=1, u1 fixed priority, u2 RD_LAT=2, each with its own RAM model.
module tb_ram_port_arbiter;
    logic clk;
    logic rst;
    logic load;
    int   n_cmp;
    int   n_err;

    ram_port_arbiter_if if0 ();
    ram_port_arbiter_if if1 ();
    ram_port_arbiter_if if2 ();

    ram_port_arbiter #(.RD_LAT(1), .FIXED_PRIO(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    ram_port_arbiter #(.RD_LAT(1), .FIXED_PRIO(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    ram_port_arbiter #(.RD_LAT(2), .FIXED_PRIO(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memval(input int i);
        if (i == 16) return 16'h1234;
        if (i == 5)  return 16'h00AA;
        return {8'(i), ~8'(i)};
    endfunction

    // ram1 models: write and registered read at the same edge, u2 adds an output register
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];
    logic [15:0] dout0, dout1, dout2, dreg2;

    always @(posedge clk) begin
        if (load) for (int i = 0; i < 256; i++) mem0[i] <= memval(i);
        else if (if0.ram_w_en) mem0[if0.ram_addr] <= if0.ram_d_in;
        dout0 <= mem0[if0.ram_addr];
    end
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 256; i++) mem1[i] <= memval(i);
        else if (if1.ram_w_en) mem1[if1.ram_addr] <= if1.ram_d_in;
        dout1 <= mem1[if1.ram_addr];
    end
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 256; i++) mem2[i] <= memval(i);
        else if (if2.ram_w_en) mem2[if2.ram_addr] <= if2.ram_d_in;
        dreg2 <= mem2[if2.ram_addr];
        dout2 <= dreg2;
    end
    assign if0.ram_d_out = dout0;
    assign if1.ram_d_out = dout1;
    assign if2.ram_d_out = dout2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        load  = 1'b1;
        if0.a_req = 1'b1; if0.a_addr = 8'h10; if0.b_req = 1'b0; if0.b_we = 1'b0;
        if0.b_addr = 8'h00; if0.b_wdata = 16'h0000;
        if1.a_req = 1'b0; if1.a_addr = 8'h00; if1.b_req = 1'b0; if1.b_we = 1'b0;
        if1.b_addr = 8'h00; if1.b_wdata = 16'h0000;
        if2.a_req = 1'b0; if2.a_addr = 8'h00; if2.b_req = 1'b0; if2.b_we = 1'b0;
        if2.b_addr = 8'h00; if2.b_wdata = 16'h0000;

        // reset state, with A requesting to prove grants are held off
        nxt(); load = 1'b0;
        nxt(); smp();
        chk("rst_a_gnt",  32'(if0.a_gnt),    0);
        chk("rst_w_en",   32'(if0.ram_w_en), 0);
        chk("rst_addr",   32'(if0.ram_addr), 0);
        chk("rst_d_in",   32'(if0.ram_d_in), 0);
        chk("rst_rvalid", 32'({if0.a_rvalid, if0.b_rvalid}), 0);
        chk("rst_rdata",  32'({if0.a_rdata, if0.b_rdata}), 0);

        // A reads 0x10
        nxt(); rst = 1'b0; if0.a_req = 1'b0;
        nxt(); if0.a_req = 1'b1; if0.a_addr = 8'h10; smp();
        chk("t1_a_gnt", 32'(if0.a_gnt), 1);
        chk("t1_b_gnt", 32'(if0.b_gnt), 0);
        nxt(); if0.a_req = 1'b0; smp();
        chk("t1_ram_addr", 32'(if0.ram_addr), 32'h10);
        chk("t1_ram_w_en", 32'(if0.ram_w_en), 0);
        nxt(); smp();
        chk("t1_rvalid_early", 32'(if0.a_rvalid), 0);
        nxt(); smp();
        chk("t1_a_rvalid", 32'(if0.a_rvalid), 1);
        chk("t1_a_rdata",  32'(if0.a_rdata),  32'h1234);
        chk("t1_b_rvalid", 32'(if0.b_rvalid), 0);
        nxt(); smp();
        chk("t1_rvalid_pulse", 32'(if0.a_rvalid), 0);
        chk("t1_rdata_hold",   32'(if0.a_rdata),  32'h1234);

        // B writes 0xBEEF to 0x20 then reads it back
        nxt(); if0.b_req = 1'b1; if0.b_we = 1'b1; if0.b_addr = 8'h20; if0.b_wdata = 16'hBEEF; smp();
        chk("t2_wr_gnt",  32'(if0.b_gnt),    1);
        chk("t2_w_en_pre", 32'(if0.ram_w_en), 0);
        nxt(); if0.b_we = 1'b0; if0.b_wdata = 16'h0000; smp();
        chk("t2_rd_gnt", 32'(if0.b_gnt),    1);
        chk("t2_w_en",   32'(if0.ram_w_en), 1);
        chk("t2_w_addr", 32'(if0.ram_addr), 32'h20);
        chk("t2_w_data", 32'(if0.ram_d_in), 32'hBEEF);
        nxt(); if0.b_req = 1'b0; smp();
        chk("t2_w_en_once", 32'(if0.ram_w_en), 0);
        nxt(); smp();
        chk("t2_no_wr_rvalid", 32'(if0.b_rvalid), 0);
        nxt(); smp();
        chk("t2_b_rvalid", 32'(if0.b_rvalid), 1);
        chk("t2_b_rdata",  32'(if0.b_rdata),  32'hBEEF);
        nxt(); nxt();

        // both request for 6 cycles: A,B,A,B,A,B and returns in the same order
        for (int k = 0; k < 9; k++) begin
            nxt();
            if (k < 6) begin
                if0.a_req = 1'b1; if0.a_addr = 8'(48 + (k + 1) / 2);
                if0.b_req = 1'b1; if0.b_we = 1'b0; if0.b_addr = 8'(64 + k / 2);
            end else begin
                if0.a_req = 1'b0; if0.b_req = 1'b0;
            end
            smp();
            if (k < 6) begin
                chk($sformatf("t3_a_gnt%0d", k), 32'(if0.a_gnt), 32'(k % 2 == 0));
                chk($sformatf("t3_b_gnt%0d", k), 32'(if0.b_gnt), 32'(k % 2 == 1));
            end
            if (k >= 3) begin
                chk($sformatf("t3_a_rv%0d", k), 32'(if0.a_rvalid), 32'((k - 3) % 2 == 0));
                chk($sformatf("t3_b_rv%0d", k), 32'(if0.b_rvalid), 32'((k - 3) % 2 == 1));
                if ((k - 3) % 2 == 0)
                    chk($sformatf("t3_a_rd%0d", k), 32'(if0.a_rdata), 32'(memval(48 + (k - 3) / 2)));
                else
                    chk($sformatf("t3_b_rd%0d", k), 32'(if0.b_rdata), 32'(memval(64 + (k - 3) / 2)));
            end
        end

        // reset one cycle after an A grant: read dropped, write blocked, pointer back to B
        nxt(); if0.a_req = 1'b1; if0.a_addr = 8'h10; smp();
        chk("t4_a_gnt", 32'(if0.a_gnt), 1);
        nxt(); if0.a_req = 1'b0; rst = 1'b1;
        if0.b_req = 1'b1; if0.b_we = 1'b1; if0.b_addr = 8'h10; if0.b_wdata = 16'hDEAD; smp();
        chk("t4_rst_b_gnt", 32'(if0.b_gnt),    0);
        chk("t4_rst_w_en",  32'(if0.ram_w_en), 0);
        chk("t4_rst_addr",  32'(if0.ram_addr), 0);
        chk("t4_rst_rdata", 32'(if0.a_rdata),  0);
        nxt(); rst = 1'b0; if0.b_req = 1'b0; if0.b_we = 1'b0; smp();
        chk("t4_rv_drop0", 32'(if0.a_rvalid), 0);
        nxt(); smp();
        chk("t4_rv_drop1", 32'(if0.a_rvalid), 0);
        nxt(); if0.a_req = 1'b1; if0.a_addr = 8'h10; if0.b_req = 1'b1; if0.b_addr = 8'h20; smp();
        chk("t4_contend_a", 32'(if0.a_gnt), 1);
        chk("t4_contend_b", 32'(if0.b_gnt), 0);
        nxt(); if0.a_req = 1'b0; smp();
        chk("t4_b_next", 32'(if0.b_gnt), 1);
        nxt(); if0.b_req = 1'b0;
        nxt(); smp();
        chk("t4_a_rvalid", 32'(if0.a_rvalid), 1);
        chk("t4_no_dead",  32'(if0.a_rdata),  32'h1234);
        nxt(); smp();
        chk("t4_b_rdata", 32'(if0.b_rdata), 32'hBEEF);

        // fixed priority: B wins every contention
        for (int k = 0; k < 4; k++) begin
            nxt();
            if1.a_req = 1'b1; if1.a_addr = 8'h50;
            if1.b_req = (k < 3); if1.b_we = 1'b0; if1.b_addr = 8'(96 + k);
            smp();
            chk($sformatf("t5_a_gnt%0d", k), 32'(if1.a_gnt), 32'(k == 3));
            chk($sformatf("t5_b_gnt%0d", k), 32'(if1.b_gnt), 32'(k < 3));
        end
        chk("t5_b_rvalid", 32'(if1.b_rvalid), 1);
        chk("t5_b_rdata",  32'(if1.b_rdata),  32'(memval(96)));
        nxt(); if1.a_req = 1'b0;

        // RD_LAT=2: return one cycle later
        nxt(); if2.b_req = 1'b1; if2.b_we = 1'b0; if2.b_addr = 8'h05; smp();
        chk("t6_b_gnt", 32'(if2.b_gnt), 1);
        nxt(); if2.b_req = 1'b0;
        nxt();
        nxt(); smp();
        chk("t6_rv_early", 32'(if2.b_rvalid), 0);
        nxt(); smp();
        chk("t6_b_rvalid", 32'(if2.b_rvalid), 1);
        chk("t6_b_rdata",  32'(if2.b_rdata),  32'h00AA);
        chk("t6_a_rvalid", 32'(if2.a_rvalid), 0);

        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
